// File: rtl/bramfifo_fwft.sv
// Single-clock FIFO on simple dual-port block RAM with fill tracking,
// thresholds, sticky error flags and an optional first-word-fall-through stage.
module bramfifo_fwft #(
   parameter int DATA_  = 8,
   parameter int ADDR_  = 8,
   parameter int FWFT_  = 1,
   parameter int AFULL_ = 4,
   parameter int AEMPTY_ = 4
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             clr,
   input  logic             we,
   input  logic [DATA_-1:0] din,
   input  logic             re,
   output logic [DATA_-1:0] dout,
   output logic             dval,
   output logic             full,
   output logic             afull,
   output logic             empty,
   output logic             aempty,
   output logic [ADDR_:0]   fillc,
   output logic             ovf,
   output logic             udf
);

   localparam logic [ADDR_:0]   C_DEPTH = (ADDR_+1)'(2**ADDR_);
   localparam logic [ADDR_:0]   C_AFTH  = (ADDR_+1)'(2**ADDR_ - AFULL_);
   localparam logic [ADDR_:0]   C_AETH  = (ADDR_+1)'(AEMPTY_);
   localparam logic [ADDR_:0]   C_F1    = (ADDR_+1)'(1);
   localparam logic [ADDR_-1:0] C_P1    = (ADDR_)'(1);

   logic [DATA_-1:0] r_mem [2**ADDR_];
   logic [ADDR_-1:0] r_rp;
   logic [ADDR_-1:0] r_wp;
   logic [ADDR_:0]   r_fillc;
   logic [ADDR_:0]   r_ramc;
   logic [DATA_-1:0] r_q;
   logic [DATA_-1:0] r_dout;
   logic             r_qv;
   logic             r_dval;
   logic             r_ovf;
   logic             r_udf;

   logic             w_full;
   logic             w_empty;
   logic             w_dval;
   logic             w_wrAcc;
   logic             w_rdAcc;
   logic             w_ramRd;
   logic             w_adv;

   // r_ramc counts words still in RAM; r_fillc also counts words in flight
   // through the RAM output register and the FWFT output register.
   always_comb begin
      w_full  = (r_fillc == C_DEPTH);
      w_empty = (r_fillc == '0);
      w_dval  = (FWFT_ != 0) ? r_dval : r_qv;
      w_wrAcc = we && !w_full && !clr;
      w_rdAcc = 1'b0;
      w_ramRd = 1'b0;
      w_adv   = 1'b1;
      if (FWFT_ != 0) begin
         w_rdAcc = re && r_dval && !clr;
         w_adv   = (!r_dval || w_rdAcc) && !clr;
         w_ramRd = (r_ramc != '0) && w_adv;
      end else begin
         w_rdAcc = re && !w_empty && !clr;
         w_ramRd = w_rdAcc;
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_rp    <= '0;
         r_wp    <= '0;
         r_fillc <= '0;
         r_ramc  <= '0;
         r_qv    <= 1'b0;
         r_dval  <= 1'b0;
         r_ovf   <= 1'b0;
         r_udf   <= 1'b0;
      end else if (clr) begin
         r_rp    <= '0;
         r_wp    <= '0;
         r_fillc <= '0;
         r_ramc  <= '0;
         r_qv    <= 1'b0;
         r_dval  <= 1'b0;
         r_ovf   <= 1'b0;
         r_udf   <= 1'b0;
      end else begin
         if (w_wrAcc) r_wp <= r_wp + C_P1;
         if (w_ramRd) r_rp <= r_rp + C_P1;
         case ({w_wrAcc, w_rdAcc})
            2'b10:   r_fillc <= r_fillc + C_F1;
            2'b01:   r_fillc <= r_fillc - C_F1;
            default: r_fillc <= r_fillc;
         endcase
         case ({w_wrAcc, w_ramRd})
            2'b10:   r_ramc <= r_ramc + C_F1;
            2'b01:   r_ramc <= r_ramc - C_F1;
            default: r_ramc <= r_ramc;
         endcase
         // In standard mode w_adv is always 1, so r_qv is a one-cycle strobe.
         if (w_adv) begin
            r_qv   <= w_ramRd;
            r_dval <= r_qv;
         end
         if (we && w_full)   r_ovf <= 1'b1;
         if (re && !w_rdAcc) r_udf <= 1'b1;
      end
   end

   // Storage and data registers carry no reset, matching block RAM.
   always_ff @(posedge clk) begin
      if (w_wrAcc) r_mem[r_wp] <= din;
      if (w_ramRd) r_q <= r_mem[r_rp];
      if (w_adv && r_qv) r_dout <= r_q;
   end

   assign dout   = (FWFT_ != 0) ? r_dout : r_q;
   assign dval   = w_dval;
   assign full   = w_full;
   assign afull  = (r_fillc >= C_AFTH);
   assign empty  = w_empty;
   assign aempty = (r_fillc <= C_AETH);
   assign fillc  = r_fillc;
   assign ovf    = r_ovf;
   assign udf    = r_udf;

endmodule

// File: tb/tb_bramfifo_fwft.sv
// Directed bench for bramfifo_fwft: one FWFT and one standard-mode instance
// (8 deep) share the stimulus; each scenario checks the relevant instance.
module tb_bramfifo_fwft;

   logic       clk = 1'b0;
   logic       rst_;
   logic       clr;
   logic       we;
   logic       re;
   logic [7:0] din;

   logic [7:0] fDout, sDout;
   logic       fDval, fFull, fAfull, fEmpty, fAempty, fOvf, fUdf;
   logic       sDval, sFull, sAfull, sEmpty, sAempty, sOvf, sUdf;
   logic [3:0] fFillc, sFillc;

   int nChecks = 0;
   int nBad    = 0;

   always #5 clk = ~clk;

   bramfifo_fwft #(.DATA_(8), .ADDR_(3), .FWFT_(1), .AFULL_(4), .AEMPTY_(2)) uFwft (
      .clk(clk), .rst_(rst_), .clr(clr), .we(we), .din(din), .re(re),
      .dout(fDout), .dval(fDval), .full(fFull), .afull(fAfull), .empty(fEmpty),
      .aempty(fAempty), .fillc(fFillc), .ovf(fOvf), .udf(fUdf)
   );

   bramfifo_fwft #(.DATA_(8), .ADDR_(3), .FWFT_(0), .AFULL_(4), .AEMPTY_(2)) uStd (
      .clk(clk), .rst_(rst_), .clr(clr), .we(we), .din(din), .re(re),
      .dout(sDout), .dval(sDval), .full(sFull), .afull(sAfull), .empty(sEmpty),
      .aempty(sAempty), .fillc(sFillc), .ovf(sOvf), .udf(sUdf)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      nChecks++;
      if (got !== want) begin
         nBad++;
         $display("[TB] FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   // Drive one cycle of inputs, then return 1 time unit after the clock edge.
   task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r, input logic c);
      we  = w;
      din = d;
      re  = r;
      clr = c;
      @(posedge clk);
      #1;
      we  = 1'b0;
      re  = 1'b0;
      clr = 1'b0;
   endtask

   task automatic doReset();
      rst_ = 1'b0;
      we   = 1'b0;
      re   = 1'b0;
      clr  = 1'b0;
      din  = 8'h00;
      #3;
      rst_ = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_ = 1'b0;
      we   = 1'b0;
      re   = 1'b0;
      clr  = 1'b0;
      din  = 8'h00;
      #2;
      checkOutput("rst_fillc", 32'(fFillc), 0);
      checkOutput("rst_empty", 32'(fEmpty), 1);
      checkOutput("rst_aempty", 32'(fAempty), 1);
      checkOutput("rst_full", 32'(fFull), 0);
      checkOutput("rst_afull", 32'(fAfull), 0);
      checkOutput("rst_dval", 32'(fDval), 0);
      checkOutput("rst_ovf", 32'(fOvf), 0);
      checkOutput("rst_udf", 32'(fUdf), 0);
      checkOutput("rst_sdval", 32'(sDval), 0);
      #5;
      rst_ = 1'b1;
      @(posedge clk);
      #1;

      // Fill to capacity, overflow, then drain at full rate.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
         checkOutput("fill_fillc", 32'(fFillc), 32'(i + 1));
         checkOutput("fill_afull", 32'(fAfull), 32'(i + 1 >= 4));
         checkOutput("fill_full", 32'(fFull), 32'(i == 7));
         checkOutput("fill_aempty", 32'(fAempty), 32'(i + 1 <= 2));
      end
      checkOutput("fill_head_dval", 32'(fDval), 1);
      checkOutput("fill_head_dout", 32'(fDout), 32'h10);
      applyStimulus(1'b1, 8'h18, 1'b0, 1'b0);
      checkOutput("ovf_flag", 32'(fOvf), 1);
      checkOutput("ovf_fillc", 32'(fFillc), 8);
      checkOutput("ovf_full", 32'(fFull), 1);
      for (int i = 0; i < 8; i++) begin
         checkOutput("drain_dval", 32'(fDval), 1);
         checkOutput("drain_dout", 32'(fDout), 32'(8'h10 + i));
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      end
      checkOutput("drain_fillc", 32'(fFillc), 0);
      checkOutput("drain_empty", 32'(fEmpty), 1);
      checkOutput("drain_dval_end", 32'(fDval), 0);
      checkOutput("drain_udf", 32'(fUdf), 0);

      // FWFT latency for a single word.
      doReset();
      applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
      checkOutput("lat_empty_n", 32'(fEmpty), 0);
      checkOutput("lat_dval_n", 32'(fDval), 0);
      checkOutput("lat_fillc_n", 32'(fFillc), 1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("lat_dval_n1", 32'(fDval), 0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("lat_dval_n2", 32'(fDval), 1);
      checkOutput("lat_dout_n2", 32'(fDout), 32'hA5);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("lat_pop_dval", 32'(fDval), 0);
      checkOutput("lat_pop_empty", 32'(fEmpty), 1);
      checkOutput("lat_pop_fillc", 32'(fFillc), 0);
      checkOutput("lat_pop_udf", 32'(fUdf), 0);

      // Standard-mode reads, then a read from empty.
      doReset();
      applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h02, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("std_rd1_dval", 32'(sDval), 1);
      checkOutput("std_rd1_dout", 32'(sDout), 32'h01);
      checkOutput("std_rd1_fillc", 32'(sFillc), 1);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("std_rd2_dval", 32'(sDval), 1);
      checkOutput("std_rd2_dout", 32'(sDout), 32'h02);
      checkOutput("std_rd2_fillc", 32'(sFillc), 0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("std_rd3_dval", 32'(sDval), 0);
      checkOutput("std_rd3_udf", 32'(sUdf), 1);
      checkOutput("std_rd3_fillc", 32'(sFillc), 0);
      checkOutput("std_rd3_dout_hold", 32'(sDout), 32'h02);

      // Concurrent write/read at constant fill, wrapping the pointers.
      doReset();
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      for (int k = 0; k < 20; k++) begin
         checkOutput("stream_dval", 32'(fDval), 1);
         checkOutput("stream_dout", 32'(fDout), 32'(k));
         applyStimulus(1'b1, 8'(k + 3), 1'b1, 1'b0);
         checkOutput("stream_fillc", 32'(fFillc), 3);
         checkOutput("stream_sdval", 32'(sDval), 1);
         checkOutput("stream_sdout", 32'(sDout), 32'(k));
         checkOutput("stream_sfillc", 32'(sFillc), 3);
      end
      checkOutput("stream_ovf", 32'(fOvf), 0);
      checkOutput("stream_udf", 32'(fUdf), 0);

      // Flush with a write pending and the overflow flag set.
      doReset();
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
      checkOutput("clr_pre_ovf", 32'(fOvf), 1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("clr_pre_fillc", 32'(fFillc), 5);
      applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1);
      checkOutput("clr_fillc", 32'(fFillc), 0);
      checkOutput("clr_empty", 32'(fEmpty), 1);
      checkOutput("clr_dval", 32'(fDval), 0);
      checkOutput("clr_ovf", 32'(fOvf), 0);
      checkOutput("clr_sfillc", 32'(sFillc), 0);
      applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("clr_post_dval", 32'(fDval), 1);
      checkOutput("clr_post_dout", 32'(fDout), 32'h33);
      checkOutput("clr_post_fillc", 32'(fFillc), 1);

      // Asynchronous reset between edges, then restart.
      doReset();
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      checkOutput("arst_pre_fillc", 32'(fFillc), 6);
      #2;
      rst_ = 1'b0;
      #1;
      checkOutput("arst_fillc", 32'(fFillc), 0);
      checkOutput("arst_empty", 32'(fEmpty), 1);
      checkOutput("arst_aempty", 32'(fAempty), 1);
      checkOutput("arst_full", 32'(fFull), 0);
      checkOutput("arst_dval", 32'(fDval), 0);
      checkOutput("arst_sfillc", 32'(sFillc), 0);
      #2;
      rst_ = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("arst_post_dval", 32'(fDval), 1);
         checkOutput("arst_post_dout", 32'(fDout), 32'(8'h50 + i));
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      end
      checkOutput("arst_post_fillc", 32'(fFillc), 0);

      $display("test done: total=%0d bad=%0d", nChecks, nBad);
      $finish;
   end

endmodule
